// File: rtl/renode_apb3_arbiter_if.sv
// ============================================================================
// Module   : renode_apb3_arbiter_if
// Purpose  : APB3 completer-side bus bundle for the round-robin APB3 arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface renode_apb3_arbiter_if #(
    parameter int ADDRESS_WIDTH = 20,
    parameter int DATA_WIDTH    = 32
);
    logic [ADDRESS_WIDTH-1:0] paddr;
    logic                     pwrite;
    logic [DATA_WIDTH-1:0]    pwdata;
    logic                     psel;
    logic                     penable;
    logic                     pready;
    logic                     pslverr;
    logic [DATA_WIDTH-1:0]    prdata;

    modport master (
        output paddr, pwrite, pwdata, psel, penable,
        input  pready, pslverr, prdata
    );

    modport slave (
        input  paddr, pwrite, pwdata, psel, penable,
        output pready, pslverr, prdata
    );
endinterface

`default_nettype wire

// File: rtl/renode_apb3_arbiter.sv
// ============================================================================
// Module   : renode_apb3_arbiter
// Purpose  : Round-robin arbiter sharing one APB3 completer among several
//            requesters. Optional ACCESS timeout: RENODE_APB3_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module renode_apb3_arbiter #(
    parameter int NUM_REQUESTERS = 4,
    parameter int ADDRESS_WIDTH  = 20,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  wire logic                                    clk,
    input  wire logic                                    rst,
    input  wire logic [NUM_REQUESTERS-1:0]               req_valid,
    input  wire logic [NUM_REQUESTERS*ADDRESS_WIDTH-1:0] req_addr,
    input  wire logic [NUM_REQUESTERS-1:0]               req_write,
    input  wire logic [NUM_REQUESTERS*DATA_WIDTH-1:0]    req_wdata,
    output logic      [NUM_REQUESTERS-1:0]               rsp_done,
    output logic      [DATA_WIDTH-1:0]                   rsp_rdata,
    output logic                                         rsp_slverr,
    renode_apb3_arbiter_if.master                        apb
);

    localparam int c_GRANT_W = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;
    localparam logic [NUM_REQUESTERS-1:0] c_DONE_ONE = NUM_REQUESTERS'(1);

    if (NUM_REQUESTERS < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("renode_apb3_arbiter: NUM_REQUESTERS and TIMEOUT_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t                   r_state;
    logic [c_GRANT_W-1:0]     r_grant;
    logic [c_GRANT_W-1:0]     r_rr_ptr;
    logic [ADDRESS_WIDTH-1:0] r_paddr;
    logic                     r_pwrite;
    logic [DATA_WIDTH-1:0]    r_pwdata;
    logic                     r_psel;
    logic                     r_penable;

    logic                     w_any;
    logic [c_GRANT_W-1:0]     w_sel_idx;
    logic [ADDRESS_WIDTH-1:0] w_sel_addr;
    logic                     w_sel_write;
    logic [DATA_WIDTH-1:0]    w_sel_wdata;
    logic [c_GRANT_W-1:0]     w_next_ptr;
    logic                     w_timeout;
    logic                     w_done;

    // Scan requesters starting at the round-robin pointer; first valid wins.
    always_comb begin
        int v_idx;
        v_idx       = 0;
        w_any       = 1'b0;
        w_sel_idx   = '0;
        w_sel_addr  = '0;
        w_sel_write = 1'b0;
        w_sel_wdata = '0;
        for (int k = 0; k < NUM_REQUESTERS; k++) begin
            v_idx = int'(r_rr_ptr) + k;
            if (v_idx >= NUM_REQUESTERS) begin
                v_idx = v_idx - NUM_REQUESTERS;
            end
            if (!w_any && req_valid[v_idx]) begin
                w_any       = 1'b1;
                w_sel_idx   = c_GRANT_W'(v_idx);
                w_sel_addr  = req_addr[v_idx*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                w_sel_write = req_write[v_idx];
                w_sel_wdata = req_wdata[v_idx*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_next_ptr = (int'(r_grant) == NUM_REQUESTERS - 1) ? '0 : r_grant + 1'b1;

`ifdef RENODE_APB3_ARB_TIMEOUT_EN
    localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_CNT_W-1:0] r_wait_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt <= '0;
        end else if (r_state == S_SETUP) begin
            r_wait_cnt <= '0;
        end else if (r_state == S_ACCESS && !apb.pready && !w_timeout) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_state == S_ACCESS) && (r_wait_cnt == c_CNT_W'(TIMEOUT_CYCLES));
`else
    assign w_timeout = 1'b0;
`endif

    // Timeout takes priority so a late pready can never complete the transfer twice.
    assign w_done     = (r_state == S_ACCESS) && (apb.pready || w_timeout);
    assign rsp_done   = w_done ? (c_DONE_ONE << r_grant) : '0;
    assign rsp_rdata  = (w_done && !r_pwrite && !w_timeout) ? apb.prdata : '0;
    assign rsp_slverr = w_done && (w_timeout || apb.pslverr);

    assign apb.paddr   = r_paddr;
    assign apb.pwrite  = r_pwrite;
    assign apb.pwdata  = r_pwdata;
    assign apb.psel    = r_psel;
    assign apb.penable = r_penable;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_grant   <= '0;
            r_rr_ptr  <= '0;
            r_paddr   <= '0;
            r_pwrite  <= 1'b0;
            r_pwdata  <= '0;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_grant   <= w_sel_idx;
                        r_paddr   <= w_sel_addr;
                        r_pwrite  <= w_sel_write;
                        r_pwdata  <= w_sel_write ? w_sel_wdata : '0;
                        r_psel    <= 1'b1;
                        r_penable <= 1'b0;
                        r_state   <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (w_done) begin
                        r_rr_ptr  <= w_next_ptr;
                        r_paddr   <= '0;
                        r_pwrite  <= 1'b0;
                        r_pwdata  <= '0;
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_renode_apb3_arbiter.sv
// ============================================================================
// Module   : tb_renode_apb3_arbiter
// Purpose  : Directed self-checking bench for renode_apb3_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_renode_apb3_arbiter;

    localparam int N  = 4;
    localparam int AW = 20;
    localparam int DW = 32;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*AW-1:0] req_addr;
    logic [N-1:0]    req_write;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    rsp_done;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_slverr;

    renode_apb3_arbiter_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) apb ();

    renode_apb3_arbiter #(
        .NUM_REQUESTERS(N),
        .ADDRESS_WIDTH (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_write (req_write),
        .req_wdata (req_wdata),
        .rsp_done  (rsp_done),
        .rsp_rdata (rsp_rdata),
        .rsp_slverr(rsp_slverr),
        .apb       (apb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Completer model: pready after cfg_wait wait cycles, read data derived from address.
    int   cfg_wait  = 0;
    logic cfg_stall = 1'b0;
    logic cfg_err   = 1'b0;
    int   acc_cnt;

    function automatic logic [DW-1:0] model_rdata(input logic [AW-1:0] a);
        return (a == 20'h00100) ? 32'hDEADBEEF : {12'hC0D, a};
    endfunction

    assign apb.pready  = apb.psel && apb.penable && !cfg_stall && (acc_cnt >= cfg_wait);
    assign apb.pslverr = cfg_err;
    assign apb.prdata  = model_rdata(apb.paddr);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_cnt <= 0;
        end else if (apb.psel && apb.penable && !apb.pready) begin
            acc_cnt <= acc_cnt + 1;
        end else begin
            acc_cnt <= 0;
        end
    end

    // Requester model: valid while issued transfers exceed completed ones.
    int          issued[N];
    int          completed[N];
    logic [AW-1:0] ra[N];
    logic          rw[N];
    logic [DW-1:0] rd[N];

    always_comb begin
        req_valid = '0;
        req_addr  = '0;
        req_write = '0;
        req_wdata = '0;
        for (int i = 0; i < N; i++) begin
            req_valid[i]          = (issued[i] != completed[i]);
            req_addr[i*AW +: AW]  = ra[i];
            req_write[i]          = rw[i];
            req_wdata[i*DW +: DW] = rd[i];
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (rsp_done[i]) completed[i] <= completed[i] + 1;
        end
    end

    typedef struct {
        int            idx;
        logic [AW-1:0] addr;
        logic          wr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        logic          err;
    } sb_t;

    sb_t sb[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int i, input logic [AW-1:0] a, input logic w,
                         input logic [DW-1:0] d, input logic err, input logic tmo);
        sb_t e;
        ra[i] = a;
        rw[i] = w;
        rd[i] = d;
        issued[i] = issued[i] + 1;
        e.idx   = i;
        e.addr  = a;
        e.wr    = w;
        e.wdata = d;
        e.rdata = (w || tmo) ? '0 : model_rdata(a);
        e.err   = err || tmo;
        sb.push_back(e);
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 64'(sb.size()), 64'd0);
    endtask

    // Scoreboard checker: every completion must match the oldest expected transfer.
    always @(negedge clk) begin
        sb_t e;
        if (!rst && rsp_done != '0) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_done", 64'(rsp_done), 64'd0);
            end else begin
                e = sb.pop_front();
                chk("sb_done_onehot", 64'(rsp_done), 64'(1) << e.idx);
                chk("sb_paddr", 64'(apb.paddr), 64'(e.addr));
                chk("sb_pwrite", 64'(apb.pwrite), 64'(e.wr));
                chk("sb_pwdata", 64'(apb.pwdata), e.wr ? 64'(e.wdata) : 64'd0);
                chk("sb_rdata", 64'(rsp_rdata), 64'(e.rdata));
                chk("sb_slverr", 64'(rsp_slverr), 64'(e.err));
            end
        end
    end

    initial begin
        int base;
        int pen;
        int n;
        logic got;

        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            issued[i]    = 0;
            completed[i] = 0;
            ra[i]        = '0;
            rw[i]        = 1'b0;
            rd[i]        = '0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_psel", 64'(apb.psel), 64'd0);
        chk("rst_penable", 64'(apb.penable), 64'd0);
        chk("rst_paddr", 64'(apb.paddr), 64'd0);
        chk("rst_done", 64'(rsp_done), 64'd0);
        chk("rst_rdata", 64'(rsp_rdata), 64'd0);
        chk("rst_slverr", 64'(rsp_slverr), 64'd0);

        // Single read, zero-wait completer.
        issue(0, 20'h00100, 1'b0, '0, 1'b0, 1'b0);
        tick();
        chk("rd_setup_psel", 64'(apb.psel), 64'd1);
        chk("rd_setup_penable", 64'(apb.penable), 64'd0);
        chk("rd_setup_paddr", 64'(apb.paddr), 64'h100);
        chk("rd_setup_done", 64'(rsp_done), 64'd0);
        tick();
        chk("rd_access_penable", 64'(apb.penable), 64'd1);
        chk("rd_access_done", 64'(rsp_done), 64'b0001);
        chk("rd_access_rdata", 64'(rsp_rdata), 64'hDEADBEEF);
        chk("rd_access_slverr", 64'(rsp_slverr), 64'd0);
        tick();
        chk("rd_idle_psel", 64'(apb.psel), 64'd0);
        chk("rd_idle_done", 64'(rsp_done), 64'd0);
        chk("rd_idle_rdata", 64'(rsp_rdata), 64'd0);

        // Fresh pointer: requesters 1 and 3 together, then all four with 0 twice.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        issue(1, 20'h00014, 1'b0, '0, 1'b0, 1'b0);
        issue(3, 20'h0003C, 1'b0, '0, 1'b0, 1'b0);
        drain("rr_pair_drain", 40);
        issue(0, 20'h00200, 1'b1, 32'h11112222, 1'b0, 1'b0);
        issue(1, 20'h00204, 1'b0, '0,           1'b0, 1'b0);
        issue(2, 20'h00208, 1'b1, 32'h33334444, 1'b0, 1'b0);
        issue(3, 20'h0020C, 1'b0, '0,           1'b0, 1'b0);
        issue(0, 20'h00200, 1'b1, 32'h11112222, 1'b0, 1'b0);
        drain("rr_all_drain", 60);

        // Write with five wait cycles.
        cfg_wait = 5;
        base = completed[2];
        issue(2, 20'h00008, 1'b1, 32'h5A5A5A5A, 1'b0, 1'b0);
        tick();
        chk("wr_setup_pwdata", 64'(apb.pwdata), 64'h5A5A5A5A);
        pen = 0;
        n   = 0;
        got = 1'b0;
        while (!got && n < 30) begin
            tick();
            n++;
            if (apb.penable) begin
                pen++;
                chk("wr_pwdata_stable", 64'(apb.pwdata), 64'h5A5A5A5A);
            end
            if (rsp_done[2]) got = 1'b1;
        end
        chk("wr_penable_cycles", 64'(pen), 64'd6);
        tick();
        tick();
        chk("wr_single_done", 64'(completed[2] - base), 64'd1);
        cfg_wait = 0;

        // Completer error on a read.
        cfg_err = 1'b1;
        base = completed[1];
        issue(1, 20'h00044, 1'b0, '0, 1'b1, 1'b0);
        drain("err_drain", 20);
        cfg_err = 1'b0;
        chk("err_single_done", 64'(completed[1] - base), 64'd1);

        // Reset in the middle of ACCESS; requester keeps asking and completes after release.
        cfg_wait = 1000;
        base = completed[3];
        issue(3, 20'h00030, 1'b1, 32'hCAFEF00D, 1'b0, 1'b0);
        repeat (4) tick();
        chk("abort_pre_penable", 64'(apb.penable), 64'd1);
        rst = 1'b1;
        #1;
        chk("abort_psel", 64'(apb.psel), 64'd0);
        chk("abort_penable", 64'(apb.penable), 64'd0);
        chk("abort_done", 64'(rsp_done), 64'd0);
        tick();
        cfg_wait = 0;
        chk("abort_no_done", 64'(completed[3] - base), 64'd0);
        rst = 1'b0;
        drain("abort_reissue_drain", 20);
        chk("abort_reissue_done", 64'(completed[3] - base), 64'd1);

`ifdef RENODE_APB3_ARB_TIMEOUT_EN
        // Completer never answers: both pending requests time out in turn.
        cfg_stall = 1'b1;
        issue(0, 20'h00050, 1'b0, '0,        1'b0, 1'b1);
        issue(1, 20'h00054, 1'b1, 32'h00000077, 1'b0, 1'b1);
        pen = 0;
        n   = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            tick();
            n++;
            if (apb.penable) pen++;
            if (rsp_done != '0) begin
                got = 1'b1;
                chk("tmo_first_done", 64'(rsp_done), 64'b0001);
            end
        end
        chk("tmo_access_cycles", 64'(pen), 64'd9);
        drain("tmo_drain", 40);
        cfg_stall = 1'b0;
`endif

        repeat (3) tick();
        chk("final_idle_psel", 64'(apb.psel), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
